// File: rtl/eeg_aram_pkg.sv
// -----------------------------------------------------------------------------
// eeg_aram_pkg
// Shared definitions for the ARAM bank controllers:
//   ARAM_ADD_AW_DFLT / ARAM_DAT_DW_DFLT : default SRAM address / word widths
//   aram_bank_st_t                      : bank controller FSM states
//   aram_dat_t                          : packed {lst, dat} output FIFO entry
// -----------------------------------------------------------------------------
package eeg_aram_pkg;

  localparam int unsigned ARAM_ADD_AW_DFLT = 12;
  localparam int unsigned ARAM_DAT_DW_DFLT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } aram_bank_st_t;

  typedef struct packed {
    logic                        lst;
    logic [ARAM_DAT_DW_DFLT-1:0] dat;
  } aram_dat_t;

endpackage

// File: rtl/eeg_aram_bank_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// CPM_FIFO
// Synchronous FIFO with a combinational head (show-ahead) output.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears pointers/count)
//   i_push       : write i_push_data at the tail
//   i_push_data  : entry to write
//   i_pop        : drop the head entry (caller guarantees non-empty)
//   o_head       : current head entry (undefined contents when empty)
//   o_empty      : no entries stored
//   o_count      : number of stored entries, 0 .. 2**ADDR_WIDTH
// -----------------------------------------------------------------------------
module CPM_FIFO #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_full;

  assign w_full  = (r_count == (ADDR_WIDTH+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // Storage is not reset; consumers must qualify o_head with ~o_empty.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (i_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_push && w_full));
    end
  end

endmodule

// File: rtl/eeg_aram_bank_ctrl.sv
// -----------------------------------------------------------------------------
// eeg_aram_bank_ctrl
// One activation-RAM bank controller. Accepts read-address bursts from the
// ARAM router arbiter side, issues single-port SRAM reads and returns the data
// with burst-last tagging through a credit-guarded output FIFO. Loader writes
// share the SRAM and always win the cycle.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   AARB_ADD_VLD/LST/RDY/ADD       : read-address channel (RDY independent of VLD)
//   AARB_DAT_VLD/LST/RDY/DAT       : read-data channel, DAT/LST from FIFO head
//   WR_VLD/WR_RDY/WR_ADD/WR_DAT    : loader write port, WR_RDY tied high
//   RAM_CEN/WEN/ADD/DIN, RAM_DOUT  : single-port SRAM, DOUT one cycle after read
//   BUSY                           : controller not in IDLE
// -----------------------------------------------------------------------------
module eeg_aram_bank_ctrl #(
  parameter int unsigned ARAM_ADD_AW = eeg_aram_pkg::ARAM_ADD_AW_DFLT,
  parameter int unsigned ARAM_DAT_DW = eeg_aram_pkg::ARAM_DAT_DW_DFLT,
  parameter int unsigned OUT_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   AARB_ADD_VLD,
  input  logic                   AARB_ADD_LST,
  output logic                   AARB_ADD_RDY,
  input  logic [ARAM_ADD_AW-1:0] AARB_ADD_ADD,
  output logic                   AARB_DAT_VLD,
  output logic                   AARB_DAT_LST,
  input  logic                   AARB_DAT_RDY,
  output logic [ARAM_DAT_DW-1:0] AARB_DAT_DAT,
  input  logic                   WR_VLD,
  output logic                   WR_RDY,
  input  logic [ARAM_ADD_AW-1:0] WR_ADD,
  input  logic [ARAM_DAT_DW-1:0] WR_DAT,
  output logic                   RAM_CEN,
  output logic                   RAM_WEN,
  output logic [ARAM_ADD_AW-1:0] RAM_ADD,
  output logic [ARAM_DAT_DW-1:0] RAM_DIN,
  input  logic [ARAM_DAT_DW-1:0] RAM_DOUT,
  output logic                   BUSY
);

  import eeg_aram_pkg::*;

  localparam int unsigned FAW = $clog2(OUT_DEPTH);
  localparam int unsigned CW  = FAW + 1;

  aram_bank_st_t r_state;
  aram_bank_st_t w_next;

  logic          r_if_vld;
  logic          r_if_lst;

  logic          w_empty;
  logic [CW-1:0] w_occ;
  logic [CW-1:0] w_cred;
  logic          w_pop;
  logic          w_rd_ok;
  logic          w_rd_fire;
  aram_dat_t     w_head;
  aram_dat_t     w_push_ent;

  // Credits cover both stored words and the read whose data lands next cycle;
  // a pop this cycle returns its credit immediately so a full FIFO that is
  // being drained still accepts one address per cycle.
  assign w_pop     = ~w_empty & AARB_DAT_RDY;
  assign w_cred    = w_occ + CW'(r_if_vld) - CW'(w_pop);
  assign w_rd_ok   = (r_state != DRAIN) & ~WR_VLD & (w_cred < CW'(OUT_DEPTH));
  assign w_rd_fire = w_rd_ok & AARB_ADD_VLD;

  assign w_push_ent.lst = r_if_lst;
  assign w_push_ent.dat = RAM_DOUT;

  CPM_FIFO #(
    .DATA_WIDTH (1 + ARAM_DAT_DW),
    .ADDR_WIDTH (FAW)
  ) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_if_vld),
    .i_push_data (w_push_ent),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_count     (w_occ)
  );

  // In-flight tag: the SRAM returns data one cycle after the read, so the
  // burst-last flag is carried alongside until the push. Reset drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_vld <= 1'b0;
      r_if_lst <= 1'b0;
    end else begin
      r_if_vld <= w_rd_fire;
      r_if_lst <= w_rd_fire & AARB_ADD_LST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_rd_fire) begin
          w_next = AARB_ADD_LST ? DRAIN : BURST;
        end
      end
      BURST: begin
        if (w_rd_fire && AARB_ADD_LST) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && w_head.lst) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    AARB_ADD_RDY = w_rd_ok;
    WR_RDY       = 1'b1;
    BUSY         = (r_state != IDLE);
    AARB_DAT_VLD = ~w_empty;
    AARB_DAT_LST = ~w_empty & w_head.lst;
    AARB_DAT_DAT = w_empty ? '0 : w_head.dat;
    RAM_CEN      = 1'b0;
    RAM_WEN      = 1'b0;
    RAM_ADD      = '0;
    RAM_DIN      = '0;
    if (WR_VLD) begin
      RAM_CEN = 1'b1;
      RAM_WEN = 1'b1;
      RAM_ADD = WR_ADD;
      RAM_DIN = WR_DAT;
    end else if (w_rd_fire) begin
      RAM_CEN = 1'b1;
      RAM_ADD = AARB_ADD_ADD;
    end
  end

endmodule

// File: tb/tb_eeg_aram_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eeg_aram_bank_ctrl
// Directed bench for eeg_aram_bank_ctrl: a cycle table for write/read basics
// and write/read collision, followed by hand-written burst, backpressure,
// back-to-back burst and mid-burst reset sequences. A behavioural SRAM sits on
// the RAM_* port; expected data come from a separately maintained gold image.
// -----------------------------------------------------------------------------
module tb_eeg_aram_bank_ctrl;

  localparam int AW = 12;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          AARB_ADD_VLD, AARB_ADD_LST, AARB_ADD_RDY;
  logic [AW-1:0] AARB_ADD_ADD;
  logic          AARB_DAT_VLD, AARB_DAT_LST, AARB_DAT_RDY;
  logic [DW-1:0] AARB_DAT_DAT;
  logic          WR_VLD, WR_RDY;
  logic [AW-1:0] WR_ADD;
  logic [DW-1:0] WR_DAT;
  logic          RAM_CEN, RAM_WEN;
  logic [AW-1:0] RAM_ADD;
  logic [DW-1:0] RAM_DIN, RAM_DOUT;
  logic          BUSY;

  always #5 clk = ~clk;

  eeg_aram_bank_ctrl #(
    .ARAM_ADD_AW (AW),
    .ARAM_DAT_DW (DW),
    .OUT_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .AARB_ADD_VLD (AARB_ADD_VLD),
    .AARB_ADD_LST (AARB_ADD_LST),
    .AARB_ADD_RDY (AARB_ADD_RDY),
    .AARB_ADD_ADD (AARB_ADD_ADD),
    .AARB_DAT_VLD (AARB_DAT_VLD),
    .AARB_DAT_LST (AARB_DAT_LST),
    .AARB_DAT_RDY (AARB_DAT_RDY),
    .AARB_DAT_DAT (AARB_DAT_DAT),
    .WR_VLD       (WR_VLD),
    .WR_RDY       (WR_RDY),
    .WR_ADD       (WR_ADD),
    .WR_DAT       (WR_DAT),
    .RAM_CEN      (RAM_CEN),
    .RAM_WEN      (RAM_WEN),
    .RAM_ADD      (RAM_ADD),
    .RAM_DIN      (RAM_DIN),
    .RAM_DOUT     (RAM_DOUT),
    .BUSY         (BUSY)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 7 + 3) & 15);
  endfunction

  // Behavioural single-port SRAM, preloaded on the first clock edge.
  logic [DW-1:0] sram [0:4095];
  logic [DW-1:0] sram_q    = '0;
  logic          sram_init = 1'b0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int a = 0; a < 4096; a++) sram[a] <= init_val(a);
      sram_init <= 1'b1;
    end else if (RAM_CEN) begin
      if (RAM_WEN) sram[RAM_ADD] <= RAM_DIN;
      else         sram_q        <= sram[RAM_ADD];
    end
  end
  assign RAM_DOUT = sram_q;

  logic [DW-1:0] gold [0:4095];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data-channel collector: every handshake is recorded with its cycle.
  logic [DW-1:0] cap_dat [$];
  logic          cap_lst [$];
  int            cap_cyc [$];
  always @(negedge clk) begin
    if (AARB_DAT_VLD && AARB_DAT_RDY) begin
      cap_dat.push_back(AARB_DAT_DAT);
      cap_lst.push_back(AARB_DAT_LST);
      cap_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          wr_vld;
    logic [AW-1:0] wr_add;
    logic [DW-1:0] wr_dat;
    logic          add_vld;
    logic          add_lst;
    logic [AW-1:0] add_add;
    logic          dat_rdy;
    logic          e_add_rdy;
    logic          e_dat_vld;
    logic          e_dat_lst;
    logic [DW-1:0] e_dat;
    logic          e_cen;
    logic          e_wen;
    logic [AW-1:0] e_ram_add;
    logic [DW-1:0] e_din;
    logic          e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic wv, input int wa, input int wd,
    input logic av, input logic al, input int aa, input logic dr,
    input logic ear, input logic edv, input logic edl, input int ed,
    input logic ec, input logic ew, input int era, input int edi, input logic eb);
    vec_t v;
    v.wr_vld = wv; v.wr_add = AW'(wa); v.wr_dat = DW'(wd);
    v.add_vld = av; v.add_lst = al; v.add_add = AW'(aa); v.dat_rdy = dr;
    v.e_add_rdy = ear; v.e_dat_vld = edv; v.e_dat_lst = edl; v.e_dat = DW'(ed);
    v.e_cen = ec; v.e_wen = ew; v.e_ram_add = AW'(era); v.e_din = DW'(edi);
    v.e_busy = eb;
    return v;
  endfunction

  int   seq_add [16];
  logic seq_lst [16];
  int   acc_cyc [16];
  int   last_base;

  // Presents seq_add[0..n-1] with ADD_VLD held; DAT_RDY is low for the first
  // rdy_low cycles. Then waits for n data words and checks them in order.
  task automatic run_seq(input int n, input int rdy_low);
    int idx;
    int k;
    int base;
    idx  = 0;
    k    = 0;
    base = cap_dat.size();
    last_base = base;
    AARB_DAT_RDY = (rdy_low == 0);
    while (idx < n && k < 200) begin
      if (k == rdy_low && rdy_low > 0) begin
        chk("bp_accepts_before_release", idx, 4);
        AARB_DAT_RDY = 1'b1;
      end
      AARB_ADD_VLD = 1'b1;
      AARB_ADD_ADD = AW'(seq_add[idx]);
      AARB_ADD_LST = seq_lst[idx];
      @(negedge clk);
      if (AARB_ADD_RDY) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      tick();
      k++;
    end
    AARB_ADD_VLD = 1'b0;
    AARB_ADD_LST = 1'b0;
    AARB_ADD_ADD = '0;
    AARB_DAT_RDY = 1'b1;
    chk("seq_accepted", idx, n);
    k = 0;
    while (cap_dat.size() < base + n && k < 50) begin
      tick();
      k++;
    end
    chk("seq_words", cap_dat.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < cap_dat.size()) begin
        chk($sformatf("seq_dat[%0d]", i), cap_dat[base+i], gold[seq_add[i]]);
        chk($sformatf("seq_lst[%0d]", i), cap_lst[base+i], seq_lst[i]);
      end
    end
    chk("seq_busy_after", BUSY, 1'b0);
  endtask

  vec_t vecs [11];

  initial begin
    for (int a = 0; a < 4096; a++) gold[a] = init_val(a);

    //             wv wa   wd    av al aa  dr   rdy vld lst dat  cen wen radd din  busy
    vecs[0]  = mk(0, 0,   0,    0, 0, 0,  0,   1,  0,  0,  0,   0,  0,  0,  0,   0);
    vecs[1]  = mk(1, 5,   'hA,  0, 0, 0,  0,   0,  0,  0,  0,   1,  1,  5,  'hA, 0);
    vecs[2]  = mk(0, 0,   0,    1, 1, 5,  0,   1,  0,  0,  0,   1,  0,  5,  0,   0);
    vecs[3]  = mk(0, 0,   0,    0, 0, 0,  1,   0,  0,  0,  0,   0,  0,  0,  0,   1);
    vecs[4]  = mk(0, 0,   0,    0, 0, 0,  1,   0,  1,  1,  'hA, 0,  0,  0,  0,   1);
    vecs[5]  = mk(0, 0,   0,    0, 0, 0,  0,   1,  0,  0,  0,   0,  0,  0,  0,   0);
    vecs[6]  = mk(1, 3,   'hC,  1, 1, 3,  0,   0,  0,  0,  0,   1,  1,  3,  'hC, 0);
    vecs[7]  = mk(0, 0,   0,    1, 1, 3,  0,   1,  0,  0,  0,   1,  0,  3,  0,   0);
    vecs[8]  = mk(1, 9,   7,    0, 0, 0,  1,   0,  0,  0,  0,   1,  1,  9,  7,   1);
    vecs[9]  = mk(0, 0,   0,    0, 0, 0,  1,   0,  1,  1,  'hC, 0,  0,  0,  0,   1);
    vecs[10] = mk(0, 0,   0,    0, 0, 0,  0,   1,  0,  0,  0,   0,  0,  0,  0,   0);

    rst = 1'b1;
    AARB_ADD_VLD = 1'b0; AARB_ADD_LST = 1'b0; AARB_ADD_ADD = '0;
    AARB_DAT_RDY = 1'b0;
    WR_VLD = 1'b0; WR_ADD = '0; WR_DAT = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      WR_VLD       = vecs[i].wr_vld;
      WR_ADD       = vecs[i].wr_add;
      WR_DAT       = vecs[i].wr_dat;
      AARB_ADD_VLD = vecs[i].add_vld;
      AARB_ADD_LST = vecs[i].add_lst;
      AARB_ADD_ADD = vecs[i].add_add;
      AARB_DAT_RDY = vecs[i].dat_rdy;
      if (vecs[i].wr_vld) gold[vecs[i].wr_add] = vecs[i].wr_dat;
      @(negedge clk);
      chk($sformatf("v%0d_add_rdy", i), AARB_ADD_RDY, vecs[i].e_add_rdy);
      chk($sformatf("v%0d_dat_vld", i), AARB_DAT_VLD, vecs[i].e_dat_vld);
      chk($sformatf("v%0d_dat_lst", i), AARB_DAT_LST, vecs[i].e_dat_lst);
      chk($sformatf("v%0d_dat", i),     AARB_DAT_DAT, vecs[i].e_dat);
      chk($sformatf("v%0d_ram_cen", i), RAM_CEN,      vecs[i].e_cen);
      chk($sformatf("v%0d_ram_wen", i), RAM_WEN,      vecs[i].e_wen);
      chk($sformatf("v%0d_ram_add", i), RAM_ADD,      vecs[i].e_ram_add);
      chk($sformatf("v%0d_ram_din", i), RAM_DIN,      vecs[i].e_din);
      chk($sformatf("v%0d_busy", i),    BUSY,         vecs[i].e_busy);
      chk($sformatf("v%0d_wr_rdy", i),  WR_RDY,       1'b1);
      tick();
    end
    WR_VLD = 1'b0; AARB_ADD_VLD = 1'b0; AARB_ADD_LST = 1'b0;

    // 8-word burst, consumer always ready: no bubbles, two-cycle latency.
    for (int i = 0; i < 8; i++) begin
      seq_add[i] = i;
      seq_lst[i] = (i == 7);
    end
    run_seq(8, 0);
    chk("burst_acc_span", acc_cyc[7] - acc_cyc[0], 7);
    if (cap_cyc.size() >= last_base + 8) begin
      chk("burst_latency", cap_cyc[last_base] - acc_cyc[0], 2);
      chk("burst_dat_span", cap_cyc[last_base+7] - cap_cyc[last_base], 7);
    end

    // Same burst with consumer stalled for 7 cycles: exactly 4 credits.
    run_seq(8, 7);

    // Back-to-back bursts with ADD_VLD held across the boundary.
    seq_add[0] = 10; seq_lst[0] = 1'b0;
    seq_add[1] = 11; seq_lst[1] = 1'b1;
    seq_add[2] = 20; seq_lst[2] = 1'b0;
    seq_add[3] = 21; seq_lst[3] = 1'b1;
    run_seq(4, 0);
    if (cap_cyc.size() >= last_base + 2)
      chk("b2b_second_start", acc_cyc[2], cap_cyc[last_base+1] + 1);

    // Reset pulse with one word queued and one read in flight.
    AARB_DAT_RDY = 1'b0;
    AARB_ADD_VLD = 1'b1; AARB_ADD_LST = 1'b0; AARB_ADD_ADD = AW'(30);
    @(negedge clk);
    chk("rst_acc0", AARB_ADD_RDY, 1'b1);
    tick();
    AARB_ADD_ADD = AW'(31);
    @(negedge clk);
    chk("rst_acc1", AARB_ADD_RDY, 1'b1);
    tick();
    AARB_ADD_VLD = 1'b0; AARB_ADD_ADD = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pre_vld", AARB_DAT_VLD, 1'b1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dat_vld", AARB_DAT_VLD, 1'b0);
    chk("rst_dat_lst", AARB_DAT_LST, 1'b0);
    chk("rst_dat",     AARB_DAT_DAT, '0);
    chk("rst_busy",    BUSY,         1'b0);
    chk("rst_add_rdy", AARB_ADD_RDY, 1'b1);
    chk("rst_ram_cen", RAM_CEN,      1'b0);
    tick();
    @(negedge clk);
    chk("rst_inflight_dropped", AARB_DAT_VLD, 1'b0);
    tick();

    for (int i = 0; i < 3; i++) begin
      seq_add[i] = 40 + i;
      seq_lst[i] = (i == 2);
    end
    run_seq(3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/eeg_aram_bank_ctrl.md
# eeg_aram_bank_ctrl

Per-bank activation RAM read/write controller sitting directly downstream of the ARAM router on its arbiter-side (AARB) port. It accepts granted address bursts, issues single-port SRAM reads, and returns the read words with burst-last tagging through a credit-guarded output FIFO. A loader write port shares the SRAM with priority over reads. The top level instantiates one controller per bank, ARAM_NUM_DW in total.

## Interface
- ARAM_ADD_AW, 12, SRAM word address width
- ARAM_DAT_DW, 4, SRAM word width
- OUT_DEPTH, 4, output FIFO depth in words (power of 2, ≥2)
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- AARB_ADD_VLD  in  1  read-address valid
- AARB_ADD_LST  in  1  last address of burst
- AARB_ADD_RDY  out  1  read address accepted
- AARB_ADD_ADD  in  ARAM_ADD_AW  read address
- AARB_DAT_VLD  out  1  read data valid
- AARB_DAT_LST  out  1  last word of burst
- AARB_DAT_RDY  in  1  consumer ready
- AARB_DAT_DAT  out  ARAM_DAT_DW  read data
- WR_VLD  in  1  loader write request
- WR_RDY  out  1  write accepted
- WR_ADD  in  ARAM_ADD_AW  write address
- WR_DAT  in  ARAM_DAT_DW  write data
- RAM_CEN  out  1  SRAM chip enable, active-high
- RAM_WEN  out  1  SRAM write enable, active-high, qualified by RAM_CEN
- RAM_ADD  out  ARAM_ADD_AW  SRAM address
- RAM_DIN  out  ARAM_DAT_DW  SRAM write data
- RAM_DOUT  in  ARAM_DAT_DW  SRAM read data, valid one cycle after a read
- BUSY  out  1  state != IDLE

## Operation
- FSM states: IDLE, BURST, DRAIN.
  - IDLE -> BURST on the first read-address handshake, or directly to DRAIN if that handshake carries LST.
  - BURST -> DRAIN on an address handshake with LST.
  - DRAIN -> IDLE on a data handshake with LST.
- In DRAIN, AARB_ADD_RDY = 0, so bursts never interleave.
- Credit rule: `cred = occ + inflight - pop`, where `pop = AARB_DAT_VLD & AARB_DAT_RDY`.
- Read issue condition: `rd_ok = state != DRAIN & ~WR_VLD & cred < OUT_DEPTH`.
  - AARB_ADD_RDY = rd_ok.
  - AARB_ADD_RDY does not depend on AARB_ADD_VLD.
- Write priority: WR_RDY = 1 always, and a write takes the SRAM cycle.
  - A read requested in the same cycle stalls.
  - Writes are accepted in any state.
- SRAM drive, by case:
  - Write cycle: RAM_CEN = 1, RAM_WEN = 1, RAM_ADD = WR_ADD, RAM_DIN = WR_DAT.
  - Read cycle: RAM_CEN = 1, RAM_WEN = 0, RAM_ADD = AARB_ADD_ADD.
  - Otherwise: all SRAM outputs 0.
- In-flight register: {vld, lst} captured on a read handshake. The next cycle, {RAM_DOUT, lst} is pushed into the FIFO.
- Output: AARB_DAT_VLD = ~empty; DAT/LST come from the FIFO head.
- The FIFO can never overflow by construction. An assertion flags a push while full.
- Width rule: occ and cred are $clog2(OUT_DEPTH)+1 bits wide.

## Timing
- Read latency: address handshake in cycle t -> RAM read in t -> FIFO push end of t+1 -> AARB_DAT_VLD in t+2.
- With AARB_DAT_RDY held high and no writes, one address per cycle is sustained with no bubbles.
- Backpressure: AARB_ADD_RDY falls in the same cycle cred reaches OUT_DEPTH. A pop in the current cycle frees a credit combinationally.
- Simultaneous read and write: the write wins; AARB_ADD_RDY = 0 that cycle.
- Last read of a burst: the final address handshake enters DRAIN on the next edge, so AARB_ADD_RDY is 0 from t+1.
- Reset, applied synchronously at any point including mid-burst:
  - state = IDLE; FIFO, occ and in-flight are cleared.
  - A pending in-flight read is discarded.
  - Outputs: AARB_ADD_RDY = 1 once reset is released; AARB_DAT_VLD = 0, AARB_DAT_LST = 0, AARB_DAT_DAT = 0; WR_RDY = 1; RAM_* = 0; BUSY = 0.

## Structure
- Shared package eeg_aram_pkg holds:
  - the ARAM_ADD_AW and ARAM_DAT_DW defaults;
  - the state enum, typedef aram_bank_st_t {IDLE, BURST, DRAIN};
  - typedef aram_dat_t for the packed {lst, dat} FIFO entry.
- Sub-module: CPM_FIFO holds the output buffer, with DATA_WIDTH = 1+ARAM_DAT_DW and ADDR_WIDTH = $clog2(OUT_DEPTH).
- The credit counter, in-flight register and FSM are local to this module.

## Test plan
- Write mem[5] = 0xA, then a 1-word read of address 5 with LST -> DAT = 0xA with LST = 1 at t+2; BUSY returns to 0 the cycle after the data handshake.
- 8-word burst to addresses 0..7, DAT_RDY = 1 -> 8 consecutive DAT_VLD cycles, LST on word 7 only, no bubbles.
- Same burst with DAT_RDY = 0 -> ADD_RDY drops after 4 accepts; releasing RDY resumes with data in order and none lost.
- WR_VLD asserted in the same cycle as ADD_VLD at address 3 -> write completes first, read is accepted one cycle later, and returns the newly written value.
- Burst ends with LST while the next burst's ADD_VLD is held -> ADD_RDY = 0 until the DAT LST handshake, then the second burst starts.
- rst pulsed one cycle mid-burst with 2 words in flight -> DAT_VLD = 0 the next cycle, state IDLE; a fresh burst afterwards returns correct data.
